// File: rtl/wave_pkg.sv
// Shared constants and state encodings for the wave UART array link.
package wave_pkg;

    localparam int WORD_W       = 32;
    localparam int N_WORDS      = 20;
    localparam int DELAY_FRAMES = 234;
    localparam logic [7:0] HEADER_BYTE = 8'h01;
    localparam int HEADER_LEN   = 4;
    localparam int TIMEOUT_BITS = 20;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        FR_HUNT,
        FR_PAYLOAD
    } frame_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling FSM, stop check.
module uart_rx_byte
    import wave_pkg::*;
#(
    parameter int DELAY_FRAMES = wave_pkg::DELAY_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       byte_strobe,
    output logic       stop_err
);

    localparam int CNT_W = $clog2(DELAY_FRAMES + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((DELAY_FRAMES + 1) / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DELAY_FRAMES);

    logic             rx_m, rx_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             cnt_clr, sample, strobe_n, err_n;

    assign data = shreg;

    // Two-flop synchroniser, idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // Byte FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_n;
    end

    // Next-state and sample/strobe control.
    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        sample   = 1'b0;
        strobe_n = 1'b0;
        err_n    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_clr = 1'b1;
                    sample  = 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        strobe_n = 1'b1;
                        state_n  = RX_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rx_s) state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // Bit-period counter, shift register and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_strobe <= 1'b0;
            stop_err    <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            else if (sample)       bit_idx <= bit_idx + 1'b1;
            if (sample) shreg <= {rx_s, shreg[7:1]};
            byte_strobe <= strobe_n;
            stop_err    <= err_n;
        end
    end

endmodule

// File: rtl/receive_array.sv
// Frame receiver: header hunt, payload assembly into a shadow buffer, atomic publish.
module receive_array
    import wave_pkg::*;
#(
    parameter int         DELAY_FRAMES = wave_pkg::DELAY_FRAMES,
    parameter int         N_WORDS      = wave_pkg::N_WORDS,
    parameter logic [7:0] HEADER_BYTE  = wave_pkg::HEADER_BYTE,
    parameter int         HEADER_LEN   = wave_pkg::HEADER_LEN,
    parameter int         TIMEOUT_BITS = wave_pkg::TIMEOUT_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rx,
    output logic [32*N_WORDS-1:0]   u_out,
    output logic                    valid,
    output logic                    busy,
    output logic                    frame_err
);

    localparam int N_BYTES = 4 * N_WORDS;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int HDR_W   = $clog2(HEADER_LEN + 1);
    localparam int TLIM    = TIMEOUT_BITS * (DELAY_FRAMES + 1);
    localparam int TO_W    = $clog2(TLIM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HEADER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TLIM - 1);

    logic [7:0]            data;
    logic                  strobe, stop_err;
    frame_state_t          state, state_n;
    logic [HDR_W-1:0]      hdr_cnt, hdr_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [TO_W-1:0]       tcnt;
    logic [32*N_WORDS-1:0] shadow, merged;
    logic                  timeout, publish, abort;

    uart_rx_byte #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_byte (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .data       (data),
        .byte_strobe(strobe),
        .stop_err   (stop_err)
    );

    assign timeout = (state == FR_PAYLOAD) && (tcnt == TO_LAST);

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FR_HUNT;
        else     state <= state_n;
    end

    // Header hunt, payload indexing, publish/abort decisions.
    always_comb begin
        state_n = state;
        hdr_n   = hdr_cnt;
        idx_n   = idx;
        publish = 1'b0;
        abort   = 1'b0;
        merged  = shadow;
        merged[idx*8 +: 8] = data;
        case (state)
            FR_HUNT: begin
                if (stop_err) begin
                    hdr_n = '0;
                end else if (strobe) begin
                    if (data == HEADER_BYTE) begin
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_n   = '0;
                            idx_n   = '0;
                            state_n = FR_PAYLOAD;
                        end else begin
                            hdr_n = hdr_cnt + 1'b1;
                        end
                    end else begin
                        hdr_n = '0;
                    end
                end
            end
            FR_PAYLOAD: begin
                if (stop_err || timeout) begin
                    abort   = 1'b1;
                    hdr_n   = '0;
                    state_n = FR_HUNT;
                end else if (strobe) begin
                    idx_n = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        publish = 1'b1;
                        idx_n   = '0;
                        state_n = FR_HUNT;
                    end
                end
            end
            default: state_n = FR_HUNT;
        endcase
    end

    // Counters, shadow buffer, output register and status strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt   <= '0;
            idx       <= '0;
            tcnt      <= '0;
            shadow    <= '0;
            u_out     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            hdr_cnt <= hdr_n;
            idx     <= idx_n;
            tcnt    <= (state != FR_PAYLOAD || strobe) ? '0 : tcnt + 1'b1;
            if (state == FR_PAYLOAD && strobe && !stop_err && !timeout)
                shadow <= merged;
            if (publish)
                u_out <= merged;
            valid     <= publish;
            busy      <= (state_n == FR_PAYLOAD);
            frame_err <= abort;
        end
    end

endmodule
